// File: rtl/img_ctrl_pkg.sv
// img_ctrl_pkg
// Shared definitions for the image frame sequencer and the image read/write blocks:
//   - ctrl_state_e : sequencer FSM state encoding
//   - img_mode_e   : processing mode codes carried on mode_in/mode_out
//   - Def*         : default frame geometry and address width
//   - safe_clog2   : clog2 that never returns 0, so 1-pixel dimensions still get a 1-bit field
package img_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StVdelay = 3'd1,
        StActive = 3'd2,
        StHblank = 3'd3,
        StDone   = 3'd4
    } ctrl_state_e;

    typedef enum logic [2:0] {
        ModePass      = 3'd0,
        ModeBrightAdd = 3'd1,
        ModeBrightSub = 3'd2,
        ModeInvert    = 3'd3,
        ModeThreshold = 3'd4
    } img_mode_e;

    localparam int unsigned DefWidth  = 768;
    localparam int unsigned DefHeight = 512;
    localparam int unsigned DefVblank = 100;
    localparam int unsigned DefHblank = 160;
    localparam int unsigned DefAddrW  = 20;

    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img_pos_counter.sv
// img_pos_counter
// Column / row / linear-address tracker for the frame sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero col/row/addr (frame start)
//   inc        : a pixel was issued this cycle; advance position
//   col, row   : current position
//   addr       : row*WIDTH+col of the current position
//   eol        : current column is the last of the line
//   eof        : current pixel is the last of the frame
module img_pos_counter #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned HEIGHT = 3,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned COL_W  = 2,
    parameter int unsigned ROW_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              eol,
    output logic              eof
);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        eol = (col_q == COL_W'(WIDTH - 1));
        eof = eol && (row_q == ROW_W'(HEIGHT - 1));
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clr) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (inc) begin
            if (eol) begin
                col_d = '0;
                // The last pixel leaves row/addr parked so addr never passes WIDTH*HEIGHT-1.
                if (!eof) begin
                    row_d  = row_q + ROW_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end else begin
                col_d  = col_q + COL_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = addr_q;

endmodule

// File: rtl/img_frame_ctrl.sv
// img_frame_ctrl
// Frame sequencer: on start, waits VBLANK cycles, then walks WIDTH*HEIGHT pixels one per
// cycle (stalling on sink_ready), inserting HBLANK idle cycles between lines, and finishes
// with a one-cycle ctrl_done pulse.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   start         : frame request, only honoured in IDLE (wins over abort there)
//   abort         : cancel the frame from any busy state, no ctrl_done
//   mode_in       : processing mode, latched when start is accepted
//   sink_ready    : downstream can take a pixel this cycle
//   VSYNC         : frame active (VDELAY/ACTIVE/HBLANK)
//   HSYNC         : pixel issued this cycle
//   rd_addr       : linear index of the issued pixel
//   col, row      : position of the issued pixel
//   mode_out      : latched mode for the current/last frame
//   busy          : not IDLE
//   ctrl_done     : one-cycle end-of-frame pulse
module img_frame_ctrl
    import img_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned HEIGHT = DefHeight,
    parameter int unsigned VBLANK = DefVblank,
    parameter int unsigned HBLANK = DefHblank,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic                           start,
    input  logic                           abort,
    input  logic [2:0]                     mode_in,
    input  logic                           sink_ready,
    output logic                           VSYNC,
    output logic                           HSYNC,
    output logic [ADDR_W-1:0]              rd_addr,
    output logic [safe_clog2(WIDTH)-1:0]   col,
    output logic [safe_clog2(HEIGHT)-1:0]  row,
    output logic [2:0]                     mode_out,
    output logic                           busy,
    output logic                           ctrl_done
);

    localparam int unsigned COL_W   = safe_clog2(WIDTH);
    localparam int unsigned ROW_W   = safe_clog2(HEIGHT);
    localparam int unsigned BLK_MAX = (VBLANK > HBLANK) ? VBLANK : HBLANK;
    localparam int unsigned BLK_W   = safe_clog2(BLK_MAX + 1);

    ctrl_state_e      state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [2:0]       mode_q, mode_d;
    logic             pos_clr;
    logic             pos_eol;
    logic             pos_eof;

    img_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_pos (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .clr   (pos_clr),
        .inc   (HSYNC),
        .col   (col),
        .row   (row),
        .addr  (rd_addr),
        .eol   (pos_eol),
        .eof   (pos_eof)
    );

    // Moore outputs; HSYNC is the only one that also looks at an input.
    always_comb begin
        VSYNC     = (state_q == StVdelay) || (state_q == StActive) || (state_q == StHblank);
        busy      = (state_q != StIdle);
        ctrl_done = (state_q == StDone);
        HSYNC     = (state_q == StActive) && sink_ready;
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        mode_d  = mode_q;
        pos_clr = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode_in;
                    pos_clr = 1'b1;
                    if (VBLANK == 0) begin
                        state_d = StActive;
                    end else begin
                        state_d = StVdelay;
                        blk_d   = BLK_W'(VBLANK);
                    end
                end
            end

            // The counter holds the number of blank cycles still to spend, including this one.
            StVdelay: begin
                blk_d = (blk_q != '0) ? blk_q - BLK_W'(1) : '0;
                if (blk_q <= BLK_W'(1)) begin
                    state_d = StActive;
                end
            end

            StActive: begin
                if (HSYNC && pos_eol) begin
                    if (pos_eof) begin
                        state_d = StDone;
                    end else if (HBLANK != 0) begin
                        state_d = StHblank;
                        blk_d   = BLK_W'(HBLANK);
                    end
                end
            end

            StHblank: begin
                blk_d = (blk_q != '0) ? blk_q - BLK_W'(1) : '0;
                if (blk_q <= BLK_W'(1)) begin
                    state_d = StActive;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                blk_d   = '0;
            end
        endcase

        // Abort overrides every busy-state transition; mode is deliberately kept.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            blk_d   = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            blk_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            mode_q  <= mode_d;
        end
    end

    assign mode_out = mode_q;

endmodule

// File: tb/tb_img_frame_ctrl.sv
// Bench for img_frame_ctrl: a 4x3 frame (VBLANK=2, HBLANK=3) instance driven through
// directed scenarios, with expected (addr, cycle) pairs queued at frame start and popped
// whenever HSYNC is seen; plus a 1x1, zero-blanking instance for the minimal frame.
module tb_img_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int VB = 2;
    localparam int HB = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, sink_ready;
    logic [2:0] mode_in;
    logic       VSYNC, HSYNC, busy, ctrl_done;
    logic [7:0] rd_addr;
    logic [1:0] col, row;
    logic [2:0] mode_out;

    logic       s_start, s_abort, s_ready;
    logic [2:0] s_mode_in;
    logic       s_vsync, s_hsync, s_busy, s_done;
    logic [0:0] s_addr, s_col, s_row;
    logic [2:0] s_mode_out;

    always #5 clk = ~clk;

    img_frame_ctrl #(
        .WIDTH(W), .HEIGHT(H), .VBLANK(VB), .HBLANK(HB), .ADDR_W(8)
    ) dut (
        .HCLK(clk), .HRESETn(rst_n), .start(start), .abort(abort), .mode_in(mode_in),
        .sink_ready(sink_ready), .VSYNC(VSYNC), .HSYNC(HSYNC), .rd_addr(rd_addr),
        .col(col), .row(row), .mode_out(mode_out), .busy(busy), .ctrl_done(ctrl_done)
    );

    img_frame_ctrl #(
        .WIDTH(1), .HEIGHT(1), .VBLANK(0), .HBLANK(0), .ADDR_W(1)
    ) dut_small (
        .HCLK(clk), .HRESETn(rst_n), .start(s_start), .abort(s_abort), .mode_in(s_mode_in),
        .sink_ready(s_ready), .VSYNC(s_vsync), .HSYNC(s_hsync), .rd_addr(s_addr),
        .col(s_col), .row(s_row), .mode_out(s_mode_out), .busy(s_busy), .ctrl_done(s_done)
    );

    typedef struct {
        int addr;
        int rel;
    } pix_t;

    pix_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   rel = 0;
    int   done_cnt = 0;
    int   done_rel = -1;
    int   vs_cnt = 0;
    int   d_mark;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at the negedge of every cycle of the big instance.
    task automatic sample();
        pix_t e;
        if (HSYNC === 1'b1) begin
            check("hsync_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rd_addr", 32'(rd_addr), e.addr);
                check("hsync_cycle", rel, e.rel);
                check("col", 32'(col), e.addr % W);
                check("row", 32'(row), e.addr / W);
            end
        end
        if (ctrl_done === 1'b1) begin
            done_cnt++;
            done_rel = rel;
            check("done_vsync", 32'(VSYNC), 0);
            check("done_busy", 32'(busy), 1);
        end
        if (VSYNC === 1'b1) vs_cnt++;
    endtask

    // Sample this cycle, then move to 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        rel++;
    endtask

    // Queue the frame's expected pixels and issue start; returns in cycle rel=1.
    task automatic begin_frame(input logic [2:0] m, input int stall_at, input int stall_len);
        for (int p = 0; p < W * H; p++) begin
            pix_t e;
            e.addr = p;
            e.rel  = VB + 1 + p + (p / W) * HB + ((p >= stall_at) ? stall_len : 0);
            exp_q.push_back(e);
        end
        mode_in = m;
        start   = 1'b1;
        rel     = 0;
        vs_cnt  = 0;
        tick();
        start = 1'b0;
        check("accept_busy", 32'(busy), 1);
        check("accept_vsync", 32'(VSYNC), 1);
        check("accept_mode", 32'(mode_out), 32'(m));
    endtask

    task automatic wait_done(input int bound);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < bound && done_cnt == d0; i++) tick();
        check("done_seen", done_cnt - d0, 1);
        check("idle_after_done", 32'(busy), 0);
        check("all_pixels_issued", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vsync"}, 32'(VSYNC), 0);
        check({tag, "_hsync"}, 32'(HSYNC), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(ctrl_done), 0);
        check({tag, "_addr"}, 32'(rd_addr), 0);
        check({tag, "_col"}, 32'(col), 0);
        check({tag, "_row"}, 32'(row), 0);
        check({tag, "_mode"}, 32'(mode_out), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        sink_ready = 1'b1;
        mode_in    = 3'd0;
        s_start    = 1'b0;
        s_abort    = 1'b0;
        s_ready    = 1'b1;
        s_mode_in  = 3'd2;

        #3;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Basic frame with sink always ready.
        begin_frame(3'd0, 99, 0);
        wait_done(100);
        check("f1_done_cycle", done_rel, 21);
        check("f1_vsync_cycles", vs_cnt, 20);

        // Back-pressure: sink stalls for 5 cycles when addr 5 is pending.
        begin_frame(3'd2, 5, 5);
        while (rel < 11) tick();
        sink_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_hsync", 32'(HSYNC), 0);
            check("stall_addr_hold", 32'(rd_addr), 5);
            tick();
        end
        sink_ready = 1'b1;
        wait_done(100);
        check("f2_done_cycle", done_rel, 26);
        check("f2_vsync_cycles", vs_cnt, 25);

        // Mode held for the frame; start mid-frame ignored.
        begin_frame(3'd3, 99, 0);
        while (rel < 5) tick();
        mode_in = 3'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("mode_mid_frame", 32'(mode_out), 3);
        d_mark = done_cnt;
        wait_done(100);
        check("mode_end_frame", 32'(mode_out), 3);
        check("f3_done_cycle", done_rel, 21);
        repeat (5) tick();
        check("single_done", done_cnt - d_mark, 1);
        begin_frame(3'd1, 99, 0);
        wait_done(100);
        check("f4_done_cycle", done_rel, 21);

        // Abort in the cycle addr 6 is issued.
        begin_frame(3'd4, 99, 0);
        while (rel < 12) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_vsync", 32'(VSYNC), 0);
        check("abort_done", 32'(ctrl_done), 0);
        check("abort_mode_kept", 32'(mode_out), 4);
        check("abort_left_pixels", exp_q.size(), 5);
        exp_q.delete();
        d_mark = done_cnt;
        repeat (10) tick();
        check("abort_no_done", done_cnt - d_mark, 0);
        begin_frame(3'd0, 99, 0);
        wait_done(100);
        check("after_abort_done_cycle", done_rel, 21);

        // Asynchronous reset in the middle of the first HBLANK.
        begin_frame(3'd6, 99, 0);
        while (rel < 8) tick();
        check("pre_reset_addr", 32'(rd_addr), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d_mark = done_cnt;
        tick();
        tick();
        check("reset_no_done", done_cnt - d_mark, 0);
        begin_frame(3'd0, 99, 0);
        wait_done(100);
        check("after_reset_done_cycle", done_rel, 21);
        check("after_reset_vsync_cycles", vs_cnt, 20);

        // 1x1 frame, no blanking.
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        check("small_hsync", 32'(s_hsync), 1);
        check("small_addr", 32'(s_addr), 0);
        check("small_vsync", 32'(s_vsync), 1);
        check("small_no_done_yet", 32'(s_done), 0);
        check("small_mode", 32'(s_mode_out), 2);
        @(posedge clk);
        #1;
        check("small_done", 32'(s_done), 1);
        check("small_done_hsync", 32'(s_hsync), 0);
        check("small_done_vsync", 32'(s_vsync), 0);
        check("small_done_busy", 32'(s_busy), 1);
        @(posedge clk);
        #1;
        check("small_idle_busy", 32'(s_busy), 0);
        check("small_idle_done", 32'(s_done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
